// File: rtl/montseq.sv
// Initiator-side sequencer for the bit-serial Montgomery multiplier core:
// loads operands, counts per-bit shift strobes, applies the final conditional subtraction.
module montseq #(
    parameter int WID  = 256,
    parameter int CNTW = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_vld,
    output logic           req_rdy,
    input  logic [WID-1:0] req_a,
    input  logic [WID-1:0] req_b,
    input  logic [WID-1:0] req_m,
    output logic [WID-1:0] core_a,
    output logic [WID-1:0] core_b,
    output logic [WID-1:0] core_m,
    output logic           core_ldnew,
    input  logic           core_shiften,
    input  logic [WID:0]   core_r,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [WID-1:0] res,
    output logic           busy
);

    // state | meaning
    // IDLE  | waiting for an operand set, req_rdy high
    // LOAD  | one-cycle core_ldnew strobe, bit counter cleared
    // RUN   | counting core_shiften pulses until WID bits are done
    // SUB   | final conditional subtraction of m from core_r
    // DONE  | result offered on res until res_rdy
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        SUB,
        DONE
    } state_t;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WID - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] cnt;
    logic [WID+1:0]  diff;
    logic            diff_unused;
    logic            last_pulse;

    // Bit WID of the difference only matters for out-of-contract core_r >= 2m.
    assign diff        = {1'b0, core_r} - {2'b00, core_m};
    assign diff_unused = diff[WID];
    assign last_pulse  = core_shiften && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_rdy    = 1'b0;
        core_ldnew = 1'b0;
        res_vld    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                busy    = 1'b0;
                if (req_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_ldnew = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                if (last_pulse) begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                state_nxt = DONE;
            end
            DONE: begin
                res_vld = 1'b1;
                if (res_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            core_a <= '0;
            core_b <= '0;
            core_m <= '0;
            res    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        core_a <= req_a;
                        core_b <= req_b;
                        core_m <= req_m;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                end
                RUN: begin
                    if (core_shiften) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SUB: begin
                    if (diff[WID+1]) begin
                        res <= core_r[WID-1:0];
                    end else begin
                        res <= diff[WID-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_montseq.sv
// Directed bench for montseq at WID=8 with a behavioural bit-serial Montgomery core model.
module tb_montseq;

    localparam int WID  = 8;
    localparam int CNTW = 9;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_vld;
    logic           req_rdy;
    logic [WID-1:0] req_a;
    logic [WID-1:0] req_b;
    logic [WID-1:0] req_m;
    logic [WID-1:0] core_a;
    logic [WID-1:0] core_b;
    logic [WID-1:0] core_m;
    logic           core_ldnew;
    logic           core_shiften;
    logic [WID:0]   core_r;
    logic           res_vld;
    logic           res_rdy;
    logic [WID-1:0] res;
    logic           busy;

    int n_chk = 0;
    int n_err = 0;

    montseq #(.WID(WID), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_m        (req_m),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_m       (core_m),
        .core_ldnew   (core_ldnew),
        .core_shiften (core_shiften),
        .core_r       (core_r),
        .res_vld      (res_vld),
        .res_rdy      (res_rdy),
        .res          (res),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full operation; entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input string tag, input logic [WID-1:0] a, input logic [WID-1:0] b,
                          input logic [WID-1:0] m, input int force_r, input int gap0,
                          input int gap1, input bit shift_in_load, input int hold,
                          input logic [WID-1:0] exp_res);
        int r;
        int ld_cnt;
        int early;
        int lat;
        int g;
        logic [WID-1:0] held;
        chk({tag, "_rdy_idle"}, req_rdy, 1);
        req_a   = a;
        req_b   = b;
        req_m   = m;
        req_vld = 1'b1;
        tick;
        req_vld = 1'b0;
        req_a   = '0;
        req_b   = '0;
        req_m   = '0;
        ld_cnt  = int'(core_ldnew);
        chk({tag, "_core_a"}, core_a, a);
        chk({tag, "_core_b"}, core_b, b);
        chk({tag, "_core_m"}, core_m, m);
        chk({tag, "_rdy_load"}, req_rdy, 0);
        core_shiften = shift_in_load;
        tick;
        core_shiften = 1'b0;
        r     = 0;
        early = 0;
        for (int i = 0; i < WID; i++) begin
            g = (i % 2 == 0) ? gap0 : gap1;
            for (int k = 1; k < g; k++) begin
                ld_cnt += int'(core_ldnew);
                if (res_vld || !busy) early++;
                tick;
            end
            ld_cnt += int'(core_ldnew);
            r = r + (a[i] ? int'(b) : 0);
            if (r % 2 == 1) r = r + int'(m);
            r = r / 2;
            core_r       = (i == WID - 1 && force_r >= 0) ? 9'(force_r) : 9'(r);
            core_shiften = 1'b1;
            tick;
            core_shiften = 1'b0;
            if (i < WID - 1 && (res_vld || !busy)) early++;
        end
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_ldnew_cycles"}, ld_cnt, 1);
        chk({tag, "_vld_in_sub"}, res_vld, 0);
        lat = 1;
        tick;
        lat++;
        while (!res_vld && lat < 10) begin
            tick;
            lat++;
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_res_vld"}, res_vld, 1);
        chk({tag, "_res"}, res, exp_res);
        held = res;
        for (int h = 0; h < hold; h++) begin
            core_shiften = 1'b1;
            core_r       = '0;
            tick;
            chk({tag, "_hold_vld"}, res_vld, 1);
            chk({tag, "_hold_res"}, res, held);
            chk({tag, "_hold_rdy"}, req_rdy, 0);
        end
        core_shiften = 1'b0;
        res_rdy      = 1'b1;
        tick;
        res_rdy = 1'b0;
        chk({tag, "_vld_drop"}, res_vld, 0);
        chk({tag, "_rdy_back"}, req_rdy, 1);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_res_kept"}, res, exp_res);
    endtask

    initial begin
        int vld_seen;
        rst          = 1'b1;
        req_vld      = 1'b0;
        req_a        = '0;
        req_b        = '0;
        req_m        = '0;
        core_shiften = 1'b0;
        core_r       = '0;
        res_rdy      = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_req_rdy", req_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_ldnew", core_ldnew, 0);
        chk("rst_res", res, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_core_m", core_m, 0);
        tick;

        run_op("mul5x7", 8'd5, 8'd7, 8'd13, -1, 5, 5, 1'b0, 0, 8'd1);
        run_op("mul1x1", 8'd1, 8'd1, 8'd13, -1, 5, 5, 1'b0, 0, 8'd3);
        run_op("mul0x9", 8'd0, 8'd9, 8'd13, -1, 5, 5, 1'b0, 0, 8'd0);
        run_op("stub16", 8'd3, 8'd4, 8'd13, 16, 2, 2, 1'b0, 0, 8'd3);
        run_op("stub13", 8'd3, 8'd4, 8'd13, 13, 2, 2, 1'b0, 0, 8'd0);
        run_op("stub12", 8'd3, 8'd4, 8'd13, 12, 2, 2, 1'b0, 10, 8'd12);
        run_op("gaps", 8'd5, 8'd7, 8'd13, -1, 1, 7, 1'b1, 0, 8'd1);

        core_shiften = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("idle_shift_busy", busy, 0);
            chk("idle_shift_res", res, 1);
        end
        core_shiften = 1'b0;

        req_a   = 8'd5;
        req_b   = 8'd7;
        req_m   = 8'd13;
        req_vld = 1'b1;
        tick;
        req_vld = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            core_shiften = 1'b1;
            tick;
            core_shiften = 1'b0;
            tick;
        end
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstrun_busy", busy, 0);
        chk("rstrun_rdy", req_rdy, 1);
        chk("rstrun_res", res, 0);
        chk("rstrun_core_a", core_a, 0);
        vld_seen = 0;
        for (int i = 0; i < 12; i++) begin
            core_shiften = (i % 2 == 0);
            if (res_vld) vld_seen++;
            tick;
        end
        core_shiften = 1'b0;
        chk("rstrun_no_vld", vld_seen, 0);
        chk("rstrun_idle", busy, 0);

        run_op("after_rst", 8'd5, 8'd7, 8'd13, -1, 5, 5, 1'b0, 0, 8'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
